// File: rtl/xor_checksum_pkg.sv
// Shared definitions for the xor_checksum block: FSM state encoding and
// default sizing constants.
package xor_checksum_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_MAX_LEN = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/xor_word.sv
// Combinational bitwise fold of two WIDTH-bit words: y = a ^ b.
module xor_word #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Pure bitwise XOR, no state.
    assign y = a ^ b;

endmodule

// File: rtl/xor_checksum.sv
// XOR checksum over a valid/ready burst of up to MAX_LEN beats.
// IDLE -> (start) -> ACCUM -> (last beat or MAX_LEN beats) -> DONE -> (out handshake) -> IDLE.
// Optional feature: define XOR_CHECKSUM_PARITY_EN to add out_parity, the
// XOR-reduction of out_data, registered alongside the result.
module xor_checksum
    import xor_checksum_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_count,
    output logic                             out_err,
`ifdef XOR_CHECKSUM_PARITY_EN
    output logic                             out_parity,
`endif
    output logic                             busy
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_res_data;
    logic [CNT_W-1:0]   r_res_count;
    logic               r_res_err;
`ifdef XOR_CHECKSUM_PARITY_EN
    logic               r_res_parity;
`endif

    logic [WIDTH-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               w_accept;
    logic               w_at_limit;
    logic               w_final;
    logic               w_out_hs;

    xor_word #(.WIDTH(WIDTH)) u_fold (
        .a (r_acc),
        .b (in_data),
        .y (w_acc_nxt)
    );

    assign w_count_nxt = r_count + CNT_W'(1);
    assign w_accept    = in_valid && (r_state == ACCUM);
    assign w_at_limit  = (w_count_nxt == MAX_CNT);
    assign w_final     = w_accept && (in_last || w_at_limit);
    assign w_out_hs    = (r_state == DONE) && out_ready;

    // State register; reset drops straight to IDLE from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_final) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                busy        = 1'b0;
            end
        endcase
    end

    // Accumulator, beat count and the held result; the result registers are
    // zero outside DONE so the outputs read 0 whenever out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_res_data   <= '0;
            r_res_count  <= '0;
            r_res_err    <= 1'b0;
`ifdef XOR_CHECKSUM_PARITY_EN
            r_res_parity <= 1'b0;
`endif
        end else begin
            if ((r_state == IDLE) && start) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (w_accept) begin
                r_acc   <= w_acc_nxt;
                r_count <= w_count_nxt;
            end

            if (w_final) begin
                r_res_data   <= w_acc_nxt;
                r_res_count  <= w_count_nxt;
                // Hitting the limit only counts as truncation when the beat
                // did not itself carry in_last.
                r_res_err    <= w_at_limit && !in_last;
`ifdef XOR_CHECKSUM_PARITY_EN
                r_res_parity <= ^w_acc_nxt;
`endif
            end else if (w_out_hs) begin
                r_res_data   <= '0;
                r_res_count  <= '0;
                r_res_err    <= 1'b0;
`ifdef XOR_CHECKSUM_PARITY_EN
                r_res_parity <= 1'b0;
`endif
            end
        end
    end

    assign out_data   = r_res_data;
    assign out_count  = r_res_count;
    assign out_err    = r_res_err;
`ifdef XOR_CHECKSUM_PARITY_EN
    assign out_parity = r_res_parity;
`endif

endmodule

// File: tb/tb_xor_checksum.sv
// Directed testbench for xor_checksum with WIDTH=8, MAX_LEN=4.
// Define XOR_CHECKSUM_PARITY_EN to also exercise out_parity.
module tb_xor_checksum;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
`ifdef XOR_CHECKSUM_PARITY_EN
    logic             out_parity;
`endif
    logic             busy;

    int n_pass;
    int n_total;

    xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_err    (out_err),
`ifdef XOR_CHECKSUM_PARITY_EN
        .out_parity (out_parity),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [WIDTH-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({in_ready, out_valid, out_data, out_count, out_err, busy} !== '0) begin
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h cnt=%0d err=%b busy=%b, need all 0",
                     in_ready, out_valid, out_data, out_count, out_err, busy);
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            $display("FAIL reset_idle: got rdy=%b vld=%b busy=%b, need 000", in_ready, out_valid, busy);
        end else n_pass++;
    endtask

    task automatic test_idle_ignore();
        in_valid = 1'b1;
        in_data  = 8'hC3;
        in_last  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_total++;
        if ({busy, in_ready, out_valid, out_data} !== '0) begin
            $display("FAIL idle_ignore: got busy=%b rdy=%b vld=%b data=%h, need 0", busy, in_ready, out_valid, out_data);
        end else n_pass++;
    endtask

    task automatic test_basic();
        do_start();
        n_total++;
        if ({busy, in_ready, out_valid} !== 3'b110) begin
            $display("FAIL accum_flags: got busy=%b rdy=%b vld=%b, need 110", busy, in_ready, out_valid);
        end else n_pass++;
        beat(8'hA5, 1'b0);
        beat(8'h0F, 1'b0);
        n_total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL basic_no_early_valid: got %b, need 0", out_valid);
        end else n_pass++;
        beat(8'hFF, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL basic_valid: got vld=%b rdy=%b, need vld=1 rdy=0", out_valid, in_ready);
        end else n_pass++;
        n_total++;
        if (out_data !== 8'h55) begin
            $display("FAIL basic_data: got %h, need 55", out_data);
        end else n_pass++;
        n_total++;
        if (out_count !== 3'd3 || out_err !== 1'b0) begin
            $display("FAIL basic_count_err: got cnt=%0d err=%b, need cnt=3 err=0", out_count, out_err);
        end else n_pass++;
    endtask

    // Expects DONE holding 0x55/3 on entry.
    task automatic test_backpressure();
        out_ready = 1'b0;
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 8'h55 || out_count !== 3'd3 || in_ready !== 1'b0) begin
                $display("FAIL backpressure_hold[%0d]: got vld=%b data=%h cnt=%0d rdy=%b, need 1 55 3 0",
                         i, out_valid, out_data, out_count, in_ready);
            end else n_pass++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        // start stays high through the handshake and must be ignored.
        handshake();
        n_total++;
        if ({busy, out_valid, out_data, out_count} !== '0) begin
            $display("FAIL backpressure_release: got busy=%b vld=%b data=%h cnt=%0d, need 0",
                     busy, out_valid, out_data, out_count);
        end else n_pass++;
        start = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0) begin
            $display("FAIL start_in_done_ignored: got busy=%b, need 0", busy);
        end else n_pass++;
    endtask

    task automatic test_truncation();
        do_start();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h08, 1'b0);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F || out_count !== 3'd4 || out_err !== 1'b1) begin
            $display("FAIL trunc_nolast: got vld=%b data=%h cnt=%0d err=%b, need 1 0f 4 1",
                     out_valid, out_data, out_count, out_err);
        end else n_pass++;
        handshake();
        do_start();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h08, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F || out_count !== 3'd4 || out_err !== 1'b0) begin
            $display("FAIL trunc_withlast: got vld=%b data=%h cnt=%0d err=%b, need 1 0f 4 0",
                     out_valid, out_data, out_count, out_err);
        end else n_pass++;
        handshake();
        n_total++;
        if ({out_valid, out_err, busy} !== 3'b000) begin
            $display("FAIL trunc_clear: got vld=%b err=%b busy=%b, need 000", out_valid, out_err, busy);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_accum();
        do_start();
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, in_ready, out_valid, out_data, out_count, out_err} !== '0) begin
            $display("FAIL reset_mid_accum: got busy=%b rdy=%b vld=%b data=%h cnt=%0d err=%b, need 0",
                     busy, in_ready, out_valid, out_data, out_count, out_err);
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        beat(8'h3C, 1'b1);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_count !== 3'd1 || out_err !== 1'b0) begin
            $display("FAIL after_reset_burst: got vld=%b data=%h cnt=%0d err=%b, need 1 3c 1 0",
                     out_valid, out_data, out_count, out_err);
        end else n_pass++;
        // Asynchronous reset while DONE is held.
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, out_valid, out_data, out_count} !== '0) begin
            $display("FAIL reset_in_done: got busy=%b vld=%b data=%h cnt=%0d, need 0",
                     busy, out_valid, out_data, out_count);
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

`ifdef XOR_CHECKSUM_PARITY_EN
    task automatic test_parity();
        do_start();
        beat(8'hA5, 1'b0);
        beat(8'h0F, 1'b0);
        beat(8'hFF, 1'b1);
        n_total++;
        if (out_data !== 8'h55 || out_parity !== 1'b0) begin
            $display("FAIL parity_55: got data=%h par=%b, need 55 0", out_data, out_parity);
        end else n_pass++;
        handshake();
        n_total++;
        if (out_parity !== 1'b0) begin
            $display("FAIL parity_idle: got %b, need 0", out_parity);
        end else n_pass++;
        do_start();
        beat(8'h0C, 1'b0);
        beat(8'h02, 1'b1);
        n_total++;
        if (out_data !== 8'h0E || out_parity !== 1'b1) begin
            $display("FAIL parity_0e: got data=%h par=%b, need 0e 1", out_data, out_parity);
        end else n_pass++;
        handshake();
    endtask
`endif

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #3;
        test_reset();
        test_idle_ignore();
        test_basic();
        test_backpressure();
        test_truncation();
        test_reset_mid_accum();
`ifdef XOR_CHECKSUM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
